// File: rtl/sdram_arb.sv
// sdram_arb: registered request/acknowledge scheduler in front of the SDRAM controller.
// Keeps one command in flight and forces refresh to the front once RMAX credits are owed.
//
// state | meaning
// IDLE  | sample requests, register the winner
// CMD   | one-cycle strobe to the controller
// WAIT  | count down until the access completes
// DONE  | pulse the owner's ack (read data captured on entry)

module sdram_arb #(
    parameter int AW   = 24,
    parameter int TCMD = 8,
    parameter int TREF = 250,
    parameter int RMAX = 4
) (
    input  logic          clock,
    input  logic          reset,

    input  logic          iniReq,
    input  logic [AW-1:0] iniA,
    input  logic [7:0]    iniD,
    output logic          iniAck,

    input  logic          dlReq,
    input  logic [AW-1:0] dlA,
    input  logic [7:0]    dlD,
    output logic          dlAck,

    input  logic          cpuRd,
    input  logic          cpuWr,
    input  logic [AW-1:0] cpuA,
    input  logic [7:0]    cpuD,
    output logic [7:0]    cpuQ,
    output logic          cpuAck,

    output logic          sdrRd,
    output logic          sdrWr,
    output logic          sdrRf,
    output logic [AW-1:0] sdrA,
    output logic [15:0]   sdrD,
    input  logic [15:0]   sdrQ,

    output logic          busy
);

    localparam int CW = $clog2(TCMD);
    localparam int RW = $clog2(TREF);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WAIT,
        S_DONE
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_RF,
        OP_INI,
        OP_DL,
        OP_CWR,
        OP_CRD
    } op_t;

    state_t        r_state;
    state_t        w_state_nxt;
    op_t           r_op;
    op_t           w_gnt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [RW-1:0] r_ivl;
    logic [2:0]    r_pend;
    logic [AW-1:0] r_a;
    logic [7:0]    r_d;
    logic [7:0]    r_cpuq;
    logic          w_grant;
    logic          w_wrap;
    logic          w_ref_take;
    logic          w_unused;

    // Only the low byte of the controller data carries machine data.
    assign w_unused = ^sdrQ[15:8];

    always_comb begin
        w_gnt = OP_NONE;
        if (r_pend >= 3'(RMAX))
            w_gnt = OP_RF;
        else if (iniReq)
            w_gnt = OP_INI;
        else if (dlReq)
            w_gnt = OP_DL;
        else if (cpuWr)
            w_gnt = OP_CWR;
        else if (cpuRd)
            w_gnt = OP_CRD;
        else if (r_pend != 3'd0)
            w_gnt = OP_RF;
    end

    assign w_grant    = (r_state == S_IDLE) && (w_gnt != OP_NONE);
    assign w_wrap     = (r_ivl == RW'(TREF - 1));
    assign w_ref_take = w_grant && (w_gnt == OP_RF);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = S_CMD;
                    w_cnt_nxt   = CW'(TCMD - 1);
                end
            end
            S_CMD: begin
                w_state_nxt = S_WAIT;
                w_cnt_nxt   = r_cnt - 1'b1;
            end
            S_WAIT: begin
                if (r_cnt == '0)
                    w_state_nxt = S_DONE;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_op  <= OP_NONE;
            r_a   <= '0;
            r_d   <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_grant) begin
                r_op <= w_gnt;
                // A refresh leaves the address/data bus where the last access put it.
                case (w_gnt)
                    OP_INI: begin
                        r_a <= iniA;
                        r_d <= iniD;
                    end
                    OP_DL: begin
                        r_a <= dlA;
                        r_d <= dlD;
                    end
                    OP_CWR, OP_CRD: begin
                        r_a <= cpuA;
                        r_d <= cpuD;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_cpuq <= '0;
        else if (r_state == S_WAIT && r_cnt == '0 && r_op == OP_CRD)
            r_cpuq <= sdrQ[7:0];
    end

    // A credit earned in the same cycle a refresh is granted cancels out.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ivl  <= '0;
            r_pend <= '0;
        end else begin
            r_ivl <= w_wrap ? '0 : r_ivl + 1'b1;
            if (w_wrap && !w_ref_take) begin
                if (r_pend != 3'd7)
                    r_pend <= r_pend + 1'b1;
            end else if (w_ref_take && !w_wrap) begin
                r_pend <= r_pend - 1'b1;
            end
        end
    end

    assign sdrRd  = (r_state == S_CMD)  && (r_op == OP_CRD);
    assign sdrWr  = (r_state == S_CMD)  && (r_op == OP_INI || r_op == OP_DL || r_op == OP_CWR);
    assign sdrRf  = (r_state == S_CMD)  && (r_op == OP_RF);
    assign iniAck = (r_state == S_DONE) && (r_op == OP_INI);
    assign dlAck  = (r_state == S_DONE) && (r_op == OP_DL);
    assign cpuAck = (r_state == S_DONE) && (r_op == OP_CWR || r_op == OP_CRD);
    assign busy   = (r_state != S_IDLE);
    assign sdrA   = r_a;
    assign sdrD   = {8'd0, r_d};
    assign cpuQ   = r_cpuq;

endmodule

// File: tb/tb_sdram_arb.sv
// tb_sdram_arb: directed and randomized scenarios for sdram_arb against a
// transaction-timeline reference model (grant cycle -> strobe/ack cycles, refresh credits).

module tb_sdram_arb;

    localparam int AW   = 24;
    localparam int TCMD = 8;
    localparam int TREF = 250;
    localparam int RMAX = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          iniReq, dlReq, cpuRd, cpuWr;
    logic [AW-1:0] iniA, dlA, cpuA;
    logic [7:0]    iniD, dlD, cpuD;
    logic          iniAck, dlAck, cpuAck;
    logic [7:0]    cpuQ;
    logic          sdrRd, sdrWr, sdrRf, busy;
    logic [AW-1:0] sdrA;
    logic [15:0]   sdrD, sdrQ;

    always #5 clock = ~clock;

    sdram_arb #(.AW(AW), .TCMD(TCMD), .TREF(TREF), .RMAX(RMAX)) dut (
        .clock(clock), .reset(reset),
        .iniReq(iniReq), .iniA(iniA), .iniD(iniD), .iniAck(iniAck),
        .dlReq(dlReq), .dlA(dlA), .dlD(dlD), .dlAck(dlAck),
        .cpuRd(cpuRd), .cpuWr(cpuWr), .cpuA(cpuA), .cpuD(cpuD), .cpuQ(cpuQ), .cpuAck(cpuAck),
        .sdrRd(sdrRd), .sdrWr(sdrWr), .sdrRf(sdrRf), .sdrA(sdrA), .sdrD(sdrD), .sdrQ(sdrQ),
        .busy(busy)
    );

    wire [6:0]       w_ctl  = {busy, sdrRd, sdrWr, sdrRf, iniAck, dlAck, cpuAck};
    wire [AW+23:0]   w_data = {sdrA, sdrD, cpuQ};

    int total = 0;
    int bad   = 0;

    // Reference model: op codes 1=refresh 2=ini 3=dl 4=cpu write 5=cpu read
    int            k;
    int            m_cmd, m_ack, m_idle_from, m_pend, m_op;
    logic [AW-1:0] m_a;
    logic [7:0]    m_d, m_q;
    logic [6:0]    e_ctl;
    logic [AW+23:0] e_data;

    // Requester agents: index 0=ini 1=dl 2=cpu
    bit            go[3];
    logic [AW-1:0] ga[3];
    logic [7:0]    gd[3];
    int            last_ack[3];
    logic [1:0]    cpu_kind;
    bit            cpu_hold;
    bit            q_fixed;
    logic [15:0]   q_val;

    task automatic model_reset();
        k = 0;
        m_cmd = -100; m_ack = -100; m_idle_from = 0; m_pend = 0; m_op = 0;
        m_a = '0; m_d = '0; m_q = '0;
        for (int i = 0; i < 3; i++) last_ack[i] = -10;
    endtask

    task automatic compute_expected();
        e_ctl = {(k >= m_cmd && k <= m_ack),
                 (k == m_cmd && m_op == 5),
                 (k == m_cmd && (m_op == 2 || m_op == 3 || m_op == 4)),
                 (k == m_cmd && m_op == 1),
                 (k == m_ack && m_op == 2),
                 (k == m_ack && m_op == 3),
                 (k == m_ack && (m_op == 4 || m_op == 5))};
        e_data = {m_a, 8'h00, m_d, m_q};
    endtask

    task automatic drive_inputs();
        sdrQ = q_fixed ? q_val : 16'($urandom);
        if (iniAck) begin iniReq = 1'b0; last_ack[0] = k; end
        if (dlAck)  begin dlReq  = 1'b0; last_ack[1] = k; end
        if (cpuAck) begin
            last_ack[2] = k;
            if (!cpu_hold) begin cpuRd = 1'b0; cpuWr = 1'b0; end
        end
        if (go[0] && !iniReq && k > last_ack[0] + 1) begin
            iniReq = 1'b1; iniA = ga[0]; iniD = gd[0]; go[0] = 1'b0;
        end
        if (go[1] && !dlReq && k > last_ack[1] + 1) begin
            dlReq = 1'b1; dlA = ga[1]; dlD = gd[1]; go[1] = 1'b0;
        end
        if (go[2] && !cpuRd && !cpuWr && k > last_ack[2] + 1) begin
            cpuRd = cpu_kind[0]; cpuWr = cpu_kind[1]; cpuA = ga[2]; cpuD = gd[2]; go[2] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit wrap;
        bit rgrant;
        int w;
        wrap = (k % TREF) == TREF - 1;
        rgrant = 1'b0;
        w = 0;
        if (k == m_ack - 1 && m_op == 5) m_q = sdrQ[7:0];
        if (k >= m_idle_from) begin
            if (m_pend >= RMAX)  w = 1;
            else if (iniReq)     w = 2;
            else if (dlReq)      w = 3;
            else if (cpuWr)      w = 4;
            else if (cpuRd)      w = 5;
            else if (m_pend > 0) w = 1;
            if (w != 0) begin
                m_op = w; m_cmd = k + 1; m_ack = k + TCMD + 1; m_idle_from = k + TCMD + 2;
                rgrant = (w == 1);
                case (w)
                    2: begin m_a = iniA; m_d = iniD; end
                    3: begin m_a = dlA;  m_d = dlD;  end
                    4, 5: begin m_a = cpuA; m_d = cpuD; end
                    default: ;
                endcase
            end
        end
        if (wrap && !rgrant) m_pend = (m_pend < 7) ? m_pend + 1 : 7;
        else if (rgrant && !wrap) m_pend = m_pend - 1;
    endtask

    task automatic cycle_body();
        compute_expected();
        drive_inputs();
        model_step();
    endtask

    task automatic tick();
        @(negedge clock);
        k++;
        cycle_body();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_reset();
        cycle_body();
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (w_ctl !== 7'd0) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", w_ctl, 7'd0); end
        total++;
        if (w_data !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", w_data); end
        do_reset();
        for (int i = 0; i < 20; i++) begin
            total++;
            if (w_ctl !== e_ctl) begin bad++; $display("FAIL reset_run_ctl k=%0d got=%b exp=%b", k, w_ctl, e_ctl); end
            total++;
            if (w_data !== e_data) begin bad++; $display("FAIL reset_run_data k=%0d got=%h exp=%h", k, w_data, e_data); end
            tick();
        end
    endtask

    task automatic test_refresh_idle();
        int first_rf;
        int nrf;
        first_rf = -1;
        nrf = 0;
        do_reset();
        for (int i = 0; i < 760; i++) begin
            tick();
            total++;
            if (w_ctl !== e_ctl) begin bad++; $display("FAIL refresh_ctl k=%0d got=%b exp=%b", k, w_ctl, e_ctl); end
            if (sdrRf) begin nrf++; if (first_rf < 0) first_rf = k; end
        end
        total++;
        if (first_rf != TREF + 1) begin bad++; $display("FAIL refresh_first got=%0d exp=%0d", first_rf, TREF + 1); end
        total++;
        if (nrf != 3) begin bad++; $display("FAIL refresh_count got=%0d exp=3", nrf); end
    endtask

    task automatic test_cpu_read();
        int st;
        int ak;
        logic [AW-1:0] a_st;
        st = -1; ak = -1; a_st = '0;
        do_reset();
        q_fixed = 1'b1; q_val = 16'h00A5;
        cpu_kind = 2'b01; ga[2] = 24'h01C000; gd[2] = 8'h00; go[2] = 1'b1;
        for (int i = 0; i < 40 && ak < 0; i++) begin
            tick();
            total++;
            if (w_ctl !== e_ctl) begin bad++; $display("FAIL rd_ctl k=%0d got=%b exp=%b", k, w_ctl, e_ctl); end
            total++;
            if (w_data !== e_data) begin bad++; $display("FAIL rd_data k=%0d got=%h exp=%h", k, w_data, e_data); end
            if (sdrRd && st < 0) begin st = k; a_st = sdrA; end
            if (cpuAck) ak = k;
        end
        total++;
        if (st != 2) begin bad++; $display("FAIL rd_strobe_cycle got=%0d exp=2", st); end
        total++;
        if (ak != st + TCMD) begin bad++; $display("FAIL rd_ack_latency got=%0d exp=%0d", ak - st, TCMD); end
        total++;
        if (a_st !== 24'h01C000) begin bad++; $display("FAIL rd_addr got=%h exp=01c000", a_st); end
        q_fixed = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        total++;
        if (cpuQ !== 8'hA5) begin bad++; $display("FAIL rd_q_held got=%h exp=a5", cpuQ); end
    endtask

    task automatic test_priority();
        int a_ini, a_dl, a_cpu;
        logic [15:0] wd[$];
        a_ini = -1; a_dl = -1; a_cpu = -1;
        do_reset();
        ga[0] = 24'h000100; gd[0] = 8'h11;
        ga[1] = 24'h200000; gd[1] = 8'h3C;
        ga[2] = 24'h0ABCDE; gd[2] = 8'h5A; cpu_kind = 2'b10;
        go[0] = 1'b1; go[1] = 1'b1; go[2] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            total++;
            if (w_ctl !== e_ctl) begin bad++; $display("FAIL prio_ctl k=%0d got=%b exp=%b", k, w_ctl, e_ctl); end
            total++;
            if (w_data !== e_data) begin bad++; $display("FAIL prio_data k=%0d got=%h exp=%h", k, w_data, e_data); end
            if (sdrWr) wd.push_back(sdrD);
            if (iniAck) a_ini = k;
            if (dlAck)  a_dl  = k;
            if (cpuAck) a_cpu = k;
        end
        total++;
        if (a_ini != TCMD + 2) begin bad++; $display("FAIL prio_ini_ack got=%0d exp=%0d", a_ini, TCMD + 2); end
        total++;
        if (a_dl != a_ini + TCMD + 2) begin bad++; $display("FAIL prio_dl_ack got=%0d exp=%0d", a_dl, a_ini + TCMD + 2); end
        total++;
        if (a_cpu != a_dl + TCMD + 2) begin bad++; $display("FAIL prio_cpu_ack got=%0d exp=%0d", a_cpu, a_dl + TCMD + 2); end
        total++;
        if (wd.size() != 3) begin
            bad++; $display("FAIL prio_wr_count got=%0d exp=3", wd.size());
        end else begin
            total++;
            if (wd[0] !== 16'h0011 || wd[1] !== 16'h003C || wd[2] !== 16'h005A) begin
                bad++; $display("FAIL prio_wr_data got=%h,%h,%h exp=0011,003c,005a", wd[0], wd[1], wd[2]);
            end
        end
    endtask

    task automatic test_urgent_refresh();
        int rf_k[$];
        int rd_k[$];
        do_reset();
        cpu_hold = 1'b1; cpu_kind = 2'b01; ga[2] = 24'h123456; gd[2] = 8'h00; go[2] = 1'b1;
        for (int i = 0; i < 1300; i++) begin
            tick();
            total++;
            if (w_ctl !== e_ctl) begin bad++; $display("FAIL urgent_ctl k=%0d got=%b exp=%b", k, w_ctl, e_ctl); end
            if (sdrRf) rf_k.push_back(k);
            if (sdrRd) rd_k.push_back(k);
        end
        total++;
        if (rf_k.size() != 2) begin
            bad++; $display("FAIL urgent_rf_count got=%0d exp=2", rf_k.size());
        end else begin
            total++;
            if (rf_k[0] < RMAX * TREF + 1 || rf_k[0] > RMAX * TREF + TCMD + 2) begin
                bad++; $display("FAIL urgent_rf_first got=%0d exp=%0d..%0d", rf_k[0], RMAX * TREF + 1, RMAX * TREF + TCMD + 2);
            end
            foreach (rf_k[j]) begin
                bit found;
                found = 1'b0;
                foreach (rd_k[m]) if (rd_k[m] == rf_k[j] + TCMD + 2) found = 1'b1;
                total++;
                if (!found) begin bad++; $display("FAIL urgent_cpu_follow rf=%0d got=none exp=rd at %0d", rf_k[j], rf_k[j] + TCMD + 2); end
            end
        end
        cpu_hold = 1'b0; cpuRd = 1'b0;
    endtask

    task automatic test_rdwr_both();
        int nrd, nwr, nack;
        logic [15:0] dwr;
        nrd = 0; nwr = 0; nack = 0; dwr = '0;
        do_reset();
        cpu_kind = 2'b11; ga[2] = 24'h00ABCD; gd[2] = 8'h77; go[2] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            total++;
            if (w_ctl !== e_ctl) begin bad++; $display("FAIL both_ctl k=%0d got=%b exp=%b", k, w_ctl, e_ctl); end
            if (sdrRd) nrd++;
            if (sdrWr) begin nwr++; dwr = sdrD; end
            if (cpuAck) nack++;
        end
        total++;
        if (nrd != 0 || nwr != 1) begin bad++; $display("FAIL both_strobes got rd=%0d wr=%0d exp rd=0 wr=1", nrd, nwr); end
        total++;
        if (dwr !== 16'h0077) begin bad++; $display("FAIL both_data got=%h exp=0077", dwr); end
        total++;
        if (nack != 1) begin bad++; $display("FAIL both_ack_count got=%0d exp=1", nack); end
    endtask

    task automatic test_reset_mid();
        int st;
        int ak;
        int nack;
        logic [15:0] d_st;
        st = -1; ak = -1; nack = 0; d_st = '0;
        do_reset();
        ga[1] = 24'h3FFFF0; gd[1] = 8'hC3; go[1] = 1'b1;
        for (int i = 0; i < 20 && st < 0; i++) begin
            tick();
            if (sdrWr) st = k;
        end
        repeat (3) begin
            tick();
            total++;
            if (w_ctl !== e_ctl) begin bad++; $display("FAIL mid_pre_ctl k=%0d got=%b exp=%b", k, w_ctl, e_ctl); end
        end
        reset = 1'b0;
        #1;
        total++;
        if (w_ctl !== 7'd0) begin bad++; $display("FAIL mid_reset_ctl got=%b exp=%b", w_ctl, 7'd0); end
        total++;
        if (w_data !== '0) begin bad++; $display("FAIL mid_reset_data got=%h exp=0", w_data); end
        repeat (3) begin
            @(negedge clock);
            total++;
            if (w_ctl !== 7'd0) begin bad++; $display("FAIL mid_hold_ctl got=%b exp=%b", w_ctl, 7'd0); end
        end
        do_reset();
        for (int i = 0; i < 20; i++) begin
            total++;
            if (w_ctl !== e_ctl) begin bad++; $display("FAIL mid_post_ctl k=%0d got=%b exp=%b", k, w_ctl, e_ctl); end
            total++;
            if (w_data !== e_data) begin bad++; $display("FAIL mid_post_data k=%0d got=%h exp=%h", k, w_data, e_data); end
            if (sdrWr) d_st = sdrD;
            if (dlAck) begin nack++; ak = k; end
            tick();
        end
        total++;
        if (ak != TCMD + 1 || nack != 1) begin bad++; $display("FAIL mid_regrant got ack=%0d n=%0d exp ack=%0d n=1", ak, nack, TCMD + 1); end
        total++;
        if (d_st !== 16'h00C3) begin bad++; $display("FAIL mid_regrant_data got=%h exp=00c3", d_st); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            for (int r = 0; r < 3; r++) begin
                if (!go[r] && $urandom_range(0, 15) == 0) begin
                    go[r] = 1'b1;
                    ga[r] = AW'($urandom);
                    gd[r] = 8'($urandom);
                    if (r == 2 && !cpuRd && !cpuWr) cpu_kind = 2'($urandom_range(1, 3));
                end
            end
            tick();
            total++;
            if (w_ctl !== e_ctl) begin bad++; $display("FAIL rand_ctl k=%0d got=%b exp=%b", k, w_ctl, e_ctl); end
            total++;
            if (w_data !== e_data) begin bad++; $display("FAIL rand_data k=%0d got=%h exp=%h", k, w_data, e_data); end
        end
    endtask

    task automatic clear_agents();
        for (int i = 0; i < 3; i++) go[i] = 1'b0;
        iniReq = 1'b0; dlReq = 1'b0; cpuRd = 1'b0; cpuWr = 1'b0;
        cpu_hold = 1'b0; q_fixed = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        iniReq = 1'b0; dlReq = 1'b0; cpuRd = 1'b0; cpuWr = 1'b0;
        iniA = '0; dlA = '0; cpuA = '0; iniD = '0; dlD = '0; cpuD = '0;
        sdrQ = '0; q_val = '0; q_fixed = 1'b0; cpu_hold = 1'b0; cpu_kind = 2'b01;
        for (int i = 0; i < 3; i++) begin go[i] = 1'b0; ga[i] = '0; gd[i] = '0; end
        model_reset();

        test_reset();
        clear_agents();
        test_refresh_idle();
        clear_agents();
        test_cpu_read();
        clear_agents();
        test_priority();
        clear_agents();
        test_urgent_refresh();
        clear_agents();
        test_rdwr_both();
        clear_agents();
        test_reset_mid();
        clear_agents();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_arb.md
Name: sdram_arb

Overview:
- Single-port SDRAM access scheduler placed between the board top level and the sdram controller.
- Replaces the combinational priority mux with a registered req/ack arbiter. Requesters are:
  - the boot ROM copier (ini);
  - the OSD ROM download (dl);
  - the machine memory port (cpu);
  - periodic refresh, which the block generates itself.
- Guarantees one command in flight, fixed access timing and bounded refresh deferral.

Parameters:
- AW, 24, SDRAM byte address width.
- TCMD, 8, clock cycles from command strobe to data valid/completion (≥2).
- TREF, 250, clock cycles between refresh credits (7.8 us at 32 MHz).
- RMAX, 4, pending-refresh count at which refresh becomes top priority (≥1, ≤7).

Ports:
- clock  in  1  system clock (clock32 domain).
- reset  in  1  asynchronous, active-low reset.
- iniReq  in  1  boot copier write request, level, held until iniAck.
- iniA  in  AW  boot copier address.
- iniD  in  8  boot copier write data.
- iniAck  out  1  one-cycle completion pulse.
- dlReq  in  1  download write request, level.
- dlA  in  AW  download address.
- dlD  in  8  download data.
- dlAck  out  1  one-cycle completion pulse.
- cpuRd  in  1  machine read request, level.
- cpuWr  in  1  machine write request, level.
- cpuA  in  AW  machine address.
- cpuD  in  8  machine write data.
- cpuQ  out  8  machine read data, held until next cpu read completes.
- cpuAck  out  1  one-cycle completion pulse.
- sdrRd  out  1  controller read strobe.
- sdrWr  out  1  controller write strobe.
- sdrRf  out  1  controller refresh strobe.
- sdrA  out  AW  controller address.
- sdrD  out  16  controller write data, {8'd0, byte}.
- sdrQ  in  16  controller read data.
- busy  out  1  high while an access or refresh is in progress (states CMD/WAIT/DONE).

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All strobes, acks and busy are 0. sdrA, sdrD, cpuQ are 0. Refresh interval counter and pending count are 0.
- Reset asserted mid-access: the access is abandoned and no ack is issued. The requester re-requests after reset.

States:
- IDLE: samples requests every cycle; a winner is registered and the state moves to CMD.
- CMD (1 cycle): exactly one of sdrRd/sdrWr/sdrRf is high. sdrA and sdrD are driven from the registered grant and stay stable through CMD, WAIT and DONE.
- WAIT: down-counter loaded with TCMD-1 on entering CMD. Stays in WAIT until the counter reaches 0.
- DONE (1 cycle): the owner's ack pulses. For a cpu read, cpuQ <= sdrQ[7:0] is captured at the WAIT→DONE edge. Next state is IDLE.
- Total: request sampled in cycle n → strobe in n+1 → ack in n+TCMD+1. Minimum IDLE dwell is 1 cycle.

Request protocol:
- Requesters drop req in the cycle after ack. Because of the IDLE dwell, the same request is never granted twice.
- Request inputs are only sampled in IDLE. A change while not IDLE is ignored.

Priority in IDLE, first match wins:
1. Urgent refresh (pending ≥ RMAX).
2. iniReq.
3. dlReq.
4. cpuWr.
5. cpuRd.
6. Background refresh (pending > 0).

- cpuRd and cpuWr both high: a write is performed and a single cpuAck is issued.

Refresh accounting:
- Interval counter counts 0..TREF-1 continuously. On wrap, pending increments, saturating at 7.
- A refresh grant decrements pending by 1 at the IDLE→CMD edge. If a wrap occurs in the same cycle, the net change is 0.
- A refresh has no ack. sdrA and sdrD are held at their previous values during a refresh.

Acks and busy:
- Acks are mutually exclusive and never occur outside DONE.
- busy = state != IDLE.

Test Plan:
1. Release reset, TREF=250, no requests → sdrRf strobe at cycle ≈251 and every 250 cycles after. No other strobes. Acks stay 0.
2. cpuRd, cpuA=24'h01C000, controller returns sdrQ=16'h00A5 at data-valid → sdrRd one cycle after sampling; cpuAck exactly TCMD cycles after the strobe; cpuQ=8'hA5 and held after cpuRd drops.
3. iniReq, dlReq and cpuWr all raised in the same cycle → service order is ini, then dl, then cpu. Each ack is TCMD+2 cycles apart. Each grant's sdrA/sdrD match its own inputs (e.g. dlD=8'h3C gives sdrD=16'h003C).
4. cpuRd held continuously while pending reaches RMAX=4 → the next IDLE grant is sdrRf, and the CPU is served immediately afterwards. pending never exceeds 4 during continuous cpu traffic.
5. cpuRd=cpuWr=1, cpuD=8'h77 → only sdrWr is strobed with sdrD=16'h0077. Exactly one cpuAck pulse.
6. Assert reset during WAIT of a dl write → all outputs 0 immediately with no dlAck. After release, the held dlReq is granted afresh and completes normally.
